// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the control state encoding and the digit-counter sizing rule.
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One spare bit beyond $clog2 so N=1 still gets a legal 1-bit counter.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder cell.
// Zero latency; no flow control.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+ci, DIGIT bits per clock, start/ready/done handshake.
// Latency N=WIDTH/DIGIT cycles from accept to done; start is ignored while ready is low.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] dsum;
    logic [WIDTH-1:0] next_r;

    assign c[0] = carry;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        fa_cell u_fa (
            .a  (sh_a[i]),
            .b  (sh_b[i]),
            .ci (c[i]),
            .s  (dsum[i]),
            .co (c[i+1])
        );
    end

    // Digits enter at the top so after N shifts the LSB digit sits at bit 0.
    if (WIDTH == DIGIT) begin : g_single
        assign next_r = dsum;
    end else begin : g_multi
        assign next_r = {dsum, sh_r[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_r  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= ci;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> DIGIT;
                    sh_b  <= sh_b >> DIGIT;
                    sh_r  <= next_r;
                    carry <= c[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        s     <= next_r;
                        co    <= c[DIGIT];
                        ovf   <= c[DIGIT] ^ c[DIGIT-1];
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised, multi-cycle successor to the single-bit full-adder cell. It adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, using a chain of full-adder cells and a registered carry. Results are signalled with a start/ready/done handshake. It sits in the arithmetic datapath wherever area matters more than latency, and is the first adder in the design with sequential control and signed-overflow detection.

## Interface
- WIDTH, 8: operand and sum width; must be ≥1.
- DIGIT, 1: bits added per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT cycles per add.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only on an edge where ready=1.
- a  in  WIDTH  operand A; sampled on the accept edge only.
- b  in  WIDTH  operand B; sampled on the accept edge only.
- ci  in  1  carry-in; sampled on the accept edge only.
- ready  out  1  high when idle and able to accept start.
- done  out  1  one-cycle pulse when s/co/ovf update.
- s  out  WIDTH  sum; holds last result.
- co  out  1  carry out of MSB; holds last result.
- ovf  out  1  signed overflow, i.e. carry into MSB XOR carry out of MSB; holds last result.

## Operation
- FSM states: IDLE and RUN.
  - IDLE→RUN on start&&ready.
  - RUN→IDLE after the N-th digit edge.
- Accept edge:
  - Latch a and b into internal shift registers, and ci into the carry register.
  - Clear the digit counter (width $clog2(N)+1).
  - ready falls.
- Each RUN edge:
  - Add the low DIGIT bits of the A and B shift registers plus the carry register through a DIGIT-cell ripple.
  - Shift the digit sum into the top of the result shift register.
  - Shift the operands right by DIGIT.
  - Carry register ← cell-chain carry-out.
  - Counter increments.
- Final (N-th) RUN edge:
  - s ← completed result register; co ← final carry.
  - ovf ← XOR of the final carry and the carry into bit WIDTH-1 (the internal carry of the last digit's MSB cell).
  - done=1 for exactly one cycle; ready=1.
- start while ready=0 is ignored; no queueing.
- s, co and ovf are never disturbed mid-operation; they change only on the done edge or on reset.
- Arithmetic is unsigned modulo 2^WIDTH. co and ovf cover the unsigned and two's-complement interpretations respectively.

## Timing
- Reset values: state=IDLE, ready=1, done=0, s=0, co=0, ovf=0, carry register and counter 0.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+N. Example: WIDTH=8, DIGIT=1 gives 8 cycles.
- Throughput: one result per N cycles.
- Back-to-back: ready=1 during the done cycle, so a start in that cycle is accepted. The next done follows N cycles later with no bubble.
- Reset mid-operation: abort immediately. No done pulse; outputs return to their reset values; ready=1 in the cycle after rst deasserts.
- Operand changes after the accept edge have no effect on the current operation.
- WIDTH=DIGIT (N=1): a single RUN cycle; done occurs one cycle after accept.

## Structure
- Package serial_adder_pkg:
  - state enum (IDLE, RUN)
  - helper function for the counter width
- Sub-module fa_cell: combinational 1-bit full adder (a, b, ci → s, co). It is instantiated DIGIT times in a generate loop inside serial_adder.
- The top level holds the FSM, counter, shift registers and carry register. There is no other hierarchy.

## Test plan
- Reset: assert rst with random inputs → ready=1, done=0, s=0, co=0, ovf=0. Release rst, then start with a=8'h35, b=8'h4A, ci=0 → done exactly 8 cycles after accept; s=8'h7F, co=0, ovf=0.
- Carry/overflow (WIDTH=8, DIGIT=1):
  - 8'hFF+8'h01, ci=0 → s=8'h00, co=1, ovf=0.
  - 8'h7F+8'h01 → s=8'h80, co=0, ovf=1.
  - 8'h00+8'h00, ci=1 → s=8'h01, co=0.
- Cell truth table (WIDTH=1, DIGIT=1): all 8 combinations of a, b, ci → each done after 1 cycle. Results:
  - 000→s0 co0
  - 001→s1 co0
  - 010→s1 co0
  - 011→s0 co1
  - 111→s1 co1
  - remaining combinations by symmetry.
- Multi-bit digit (WIDTH=16, DIGIT=4): 16'hFFFF+16'h0001 → done 4 cycles after accept; s=16'h0000, co=1, ovf=0.
- Handshake:
  - A start pulsed at cycle 3 of a busy run is ignored; no extra done occurs.
  - A start held high through the done cycle with new operands 8'h10+8'h20 is accepted. s=8'h30 arrives 8 cycles later.
- Reset mid-run: assert rst at cycle 4 of 8 → no done; s=0, co=0, ovf=0, ready=1. The next add of 8'h01+8'h02 completes with s=8'h03.
